// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog: FSM state codes, register map, CTRL bit
// positions and the kick key.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_FIRE = 2'd3
    } wdt_state_e;

    localparam logic [1:0] ADR_CTRL  = 2'd0;
    localparam logic [1:0] ADR_LOAD  = 2'd1;
    localparam logic [1:0] ADR_KICK  = 2'd2;
    localparam logic [1:0] ADR_COUNT = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_IRQ_PEND = 2;
    localparam int CTRL_STATE_LO = 4;

    localparam logic [31:0] KICK_KEY = 32'h5A5A_A5A5;

    // A programmed reload of zero behaves like one tick.
    function automatic logic [31:0] load_eff(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/wdt_if.sv
// Pipelined Wishbone slave bundle for the watchdog register file.
// Handshake: a transfer is issued in any cycle with wb_cyc && wb_stb; the slave
// never stalls and answers with wb_ack exactly one cycle later, carrying read data.
interface wdt_if;
    logic [1:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_ack;
    logic        wb_stall;
    logic        wb_err;

    modport master (
        output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
        input  wb_dat_r, wb_ack, wb_stall, wb_err
    );

    modport slave (
        input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
        output wb_dat_r, wb_ack, wb_stall, wb_err
    );
endinterface

// File: rtl/wdt_prescaler.sv
// Watchdog tick generator: one-cycle tick every PRESCALE enabled cycles,
// restarted from zero by clr.
module wdt_prescaler #(
    parameter int PRESCALE = 50
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (PRESCALE < 2) ? 1 : $clog2(PRESCALE + 1);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/wdt.sv
// Windowed watchdog: counts down in RUN, raises an early warning and reloads in
// WARN, then requests a fixed-length reset pulse in FIRE before returning to IDLE.
module wdt
    import wdt_pkg::*;
#(
    parameter int PRESCALE        = 50,
    parameter int RESET_PULSE_LEN = 64
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    wdt_if.slave       bus,
    output logic       wdt_reset_o,
    output logic       wdt_irq_o,
    output wdt_state_e state
);
    localparam logic [7:0] PULSE_LAST = 8'(RESET_PULSE_LEN - 1);

    wdt_state_e  state_next;
    logic [31:0] count, count_next;
    logic [31:0] load, load_next;
    logic        irq_en, irq_en_next;
    logic        irq_pend, irq_pend_next;
    logic [7:0]  pulse_cnt, pulse_next;
    logic        presc_clr, tick, irq_set, irq_clr;
    logic        req, wr, wr_ctrl, wr_load, wr_kick;
    logic        en;
    logic [31:0] rd_mux;
    logic        unused_sel;

    assign unused_sel   = ^bus.wb_sel;
    assign bus.wb_stall = 1'b0;
    assign bus.wb_err   = 1'b0;

    assign req     = bus.wb_cyc && bus.wb_stb;
    assign wr      = req && bus.wb_we;
    assign wr_ctrl = wr && (bus.wb_adr == ADR_CTRL);
    assign wr_load = wr && (bus.wb_adr == ADR_LOAD);
    assign wr_kick = wr && (bus.wb_adr == ADR_KICK);
    assign en      = (state != ST_IDLE);

    wdt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .en      ((state == ST_RUN) || (state == ST_WARN)),
        .clr     (presc_clr),
        .tick    (tick)
    );

    always_comb begin
        state_next    = state;
        count_next    = count;
        load_next     = load;
        irq_en_next   = irq_en;
        irq_pend_next = irq_pend;
        pulse_next    = 8'd0;
        presc_clr     = 1'b0;
        irq_set       = 1'b0;
        irq_clr       = 1'b0;

        if (wr_ctrl && (state != ST_FIRE)) begin
            irq_en_next = bus.wb_dat_w[CTRL_IRQ_EN];
            irq_clr     = bus.wb_dat_w[CTRL_IRQ_PEND];
        end

        case (state)
            ST_IDLE: begin
                if (wr_load) load_next = bus.wb_dat_w;
                if (wr_ctrl && bus.wb_dat_w[CTRL_EN]) begin
                    state_next = ST_RUN;
                    count_next = load_eff(load);
                    presc_clr  = 1'b1;
                end
            end
            ST_RUN, ST_WARN: begin
                // A kick takes priority over a tick landing in the same cycle.
                if (wr_kick) begin
                    if (bus.wb_dat_w == KICK_KEY) begin
                        state_next = ST_RUN;
                        count_next = load_eff(load);
                        presc_clr  = 1'b1;
                        irq_clr    = 1'b1;
                    end else begin
                        state_next = ST_FIRE;
                    end
                end else if (tick) begin
                    if (count <= 32'd1) begin
                        if (state == ST_RUN) begin
                            irq_set    = 1'b1;
                            count_next = load_eff(load);
                            state_next = ST_WARN;
                        end else begin
                            count_next = 32'd0;
                            state_next = ST_FIRE;
                        end
                    end else begin
                        count_next = count - 32'd1;
                    end
                end
            end
            ST_FIRE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next = ST_IDLE;
                    count_next = 32'd0;
                end else begin
                    pulse_next = pulse_cnt + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (irq_set)      irq_pend_next = 1'b1;
        else if (irq_clr) irq_pend_next = 1'b0;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (bus.wb_adr)
            ADR_CTRL:  rd_mux = {26'd0, state, 1'b0, irq_pend, irq_en, en};
            ADR_LOAD:  rd_mux = load;
            ADR_COUNT: rd_mux = count;
            default:   rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            count        <= 32'd0;
            load         <= 32'hFFFF_FFFF;
            irq_en       <= 1'b0;
            irq_pend     <= 1'b0;
            pulse_cnt    <= 8'd0;
            wdt_reset_o  <= 1'b0;
            wdt_irq_o    <= 1'b0;
            bus.wb_ack   <= 1'b0;
            bus.wb_dat_r <= 32'd0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            load         <= load_next;
            irq_en       <= irq_en_next;
            irq_pend     <= irq_pend_next;
            pulse_cnt    <= pulse_next;
            wdt_reset_o  <= (state == ST_FIRE);
            wdt_irq_o    <= irq_pend && irq_en;
            bus.wb_ack   <= req;
            bus.wb_dat_r <= (req && !bus.wb_we) ? rd_mux : 32'd0;
        end
    end
endmodule
